uart_rx: RTL and testbench

Oversampling UART receiver that turns a serial line into parallel data words. Each frame is one start bit (0), `WIDTH` data bits sent LSB first, an optional parity bit and one stop bit (1). A word is presented on `P_DATA` with a one-cycle `data_valid` strobe only when the whole frame checks clean. The block sits between the external RX pin, already synchronised to `CLK`, and the core logic that consumes received words.

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Oversampling UART receiver. A frame is one start bit (0), WIDTH data bits
// LSB first, an optional parity bit and one stop bit (1); every bit lasts
// `prescale` clocks. Each bit is sampled three times around its middle and
// resolved by majority vote. A received word is presented on P_DATA with a
// single-cycle data_valid strobe only when parity and stop bit both check.
//
// Ports
//   CLK         system clock, `prescale` clocks per serial bit
//   RST         asynchronous active-high reset
//   RX_IN       serial line (already synchronised to CLK), idles high
//   prescale    clocks per bit, even values 6..30
//   PAR_EN      1: frame carries a parity bit after the data
//   PAR_TYP     parity type, 0 = even, 1 = odd
//   P_DATA      last correctly received word (registered)
//   data_valid  one-cycle strobe marking a new P_DATA
//
// prescale, PAR_EN and PAR_TYP are captured on the start edge and held for the
// whole frame, so changing them mid-frame only affects the next frame.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [4:0]       prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [4:0]       edge_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [4:0]       pre_q;
  logic             par_en_q, par_typ_q;
  logic             samp_lo, samp_mid;
  logic [WIDTH-1:0] shreg;
  logic             par_err, stop_err;

  // Per-bit timing, derived from the prescale value latched for this frame.
  logic [4:0] half;
  logic       last_edge, samp_lo_edge, samp_mid_edge, resolve_edge;
  logic       bit_val;

  assign half          = {1'b0, pre_q[4:1]};
  assign last_edge     = (edge_cnt == pre_q - 5'd1);
  assign samp_lo_edge  = (edge_cnt == half - 5'd1);
  assign samp_mid_edge = (edge_cnt == half);
  assign resolve_edge  = (edge_cnt == half + 5'd1);

  // Majority of the samples at edges h-1, h and the live value at edge h+1.
  assign bit_val = (samp_lo & samp_mid) | (samp_lo & RX_IN) | (samp_mid & RX_IN);

  logic start_glitch, frame_done;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    start_glitch = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START: begin
        if (resolve_edge && bit_val) begin
          start_glitch = 1'b1;
          state_nxt    = IDLE;
        end else if (last_edge) begin
          state_nxt = DATA;
        end
      end
      DATA:   if (last_edge && bit_cnt == LAST_BIT)
                state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (last_edge) state_nxt = STOP;
      STOP: begin
        if (last_edge) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pre_q      <= 5'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_lo    <= 1'b1;
      samp_mid   <= 1'b1;
      shreg      <= '0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state == IDLE) begin
        // The clock that first sees the line low is edge 0 of the start bit.
        if (!RX_IN) begin
          edge_cnt  <= 5'd1;
          pre_q     <= prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          bit_cnt   <= '0;
          par_err   <= 1'b0;
          stop_err  <= 1'b0;
        end else begin
          edge_cnt <= '0;
        end
      end else begin
        if (start_glitch || last_edge) edge_cnt <= '0;
        else                           edge_cnt <= edge_cnt + 5'd1;

        if (samp_lo_edge)  samp_lo  <= RX_IN;
        if (samp_mid_edge) samp_mid <= RX_IN;

        case (state)
          DATA: begin
            if (resolve_edge) shreg <= {bit_val, shreg[WIDTH-1:1]};
            if (last_edge)    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
          PARITY: if (resolve_edge) par_err <= (bit_val != ((^shreg) ^ par_typ_q));
          STOP:   if (resolve_edge) stop_err <= ~bit_val;
          default: ;
        endcase

        // The stop error is resolved at edge h+1, well before the last edge.
        if (frame_done && !par_err && !stop_err) begin
          P_DATA     <= shreg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: table-driven bench for uart_rx (WIDTH = 8). Frames are driven one
// clock after the rising edge, so bit k of a frame covers rising edges
// k*p+1 .. (k+1)*p counted from the drive point. The strobe is therefore
// visible just after the last rising edge of the stop bit, where the frame
// task samples it. A negedge monitor counts strobes and their widths.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [4:0] prescale;
  logic       PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int run      = 0;
  int max_run  = 0;
  int exp_pulses = 0;

  uart_rx #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (data_valid) begin
      if (run == 0) pulses++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  typedef struct packed {
    logic [4:0] p;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       glitch;     // flip the middle sample of every data bit
    logic       exp_valid;
    logic [7:0] exp_data;   // P_DATA expected after the frame
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input int p, input logic b, input logic glitch);
    int h;
    h = p / 2;
    RX_IN = b;
    if (glitch) begin
      tick(h);
      RX_IN = ~b;
      tick(1);
      RX_IN = b;
      tick(p - h - 1);
    end else begin
      tick(p);
    end
  endtask

  task automatic send_frame(input string name, input vec_t v);
    int p;
    p = int'(v.p);
    prescale = v.p;
    PAR_EN   = v.pe;
    PAR_TYP  = v.pt;
    send_bit(p, 1'b0, 1'b0);
    // Scramble the configuration mid-frame; the receiver must ignore it.
    prescale = (v.p == 5'd30) ? 5'd6 : 5'd30;
    PAR_EN   = ~v.pe;
    PAR_TYP  = ~v.pt;
    for (int i = 0; i < 8; i++) send_bit(p, v.data[i], v.glitch);
    if (v.pe) send_bit(p, v.par_bit, 1'b0);
    send_bit(p, v.stop_bit, 1'b0);
    if (v.exp_valid) exp_pulses++;
    check({name, " valid"}, 32'(data_valid), 32'(v.exp_valid));
    check({name, " data"},  32'(P_DATA),     32'(v.exp_data));
  endtask

  initial begin
    vec_t v;

    //            p      pe    pt    data   par   stop  glit  valid exp_data
    vecs[0]  = '{5'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55};
    vecs[1]  = '{5'd8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
    vecs[2]  = '{5'd8,  1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55};
    vecs[3]  = '{5'd8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
    vecs[4]  = '{5'd8,  1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
    vecs[5]  = '{5'd8,  1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55};
    vecs[6]  = '{5'd8,  1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07};
    vecs[7]  = '{5'd8,  1'b0, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};
    vecs[8]  = '{5'd16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55};
    vecs[9]  = '{5'd6,  1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h81};
    vecs[10] = '{5'd30, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};

    RST      = 1'b1;
    RX_IN    = 1'b1;
    prescale = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    #3;
    check("reset data",  32'(P_DATA),     32'h0);
    check("reset valid", 32'(data_valid), 32'h0);
    tick(3);
    RST = 1'b0;
    tick(4);

    // Table frames, sent back to back with no idle gap.
    for (int i = 0; i < NV; i++) send_frame($sformatf("vec%0d", i), vecs[i]);
    RX_IN = 1'b1;
    tick(2);
    check("pulse count after table", 32'(pulses), 32'(exp_pulses));

    // Two-clock low glitch on an idle line: no strobe, data held.
    prescale = 5'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(40);
    check("glitch pulses", 32'(pulses), 32'(exp_pulses));
    check("glitch data",   32'(P_DATA), 32'h3C);
    v = '{5'd8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3};
    send_frame("after glitch", v);
    RX_IN = 1'b1;
    tick(5);

    // Reset in the middle of a frame clears outputs at once.
    prescale = 5'd8;
    RX_IN    = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(12);
    RST = 1'b1;
    #1;
    check("midframe reset data",  32'(P_DATA),     32'h0);
    check("midframe reset valid", 32'(data_valid), 32'h0);
    tick(2);
    RST = 1'b0;
    tick(5);
    v = '{5'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    send_frame("after reset", v);
    RX_IN = 1'b1;
    tick(30);
    check("data held idle", 32'(P_DATA), 32'hA5);

    check("total pulses", 32'(pulses),  32'(exp_pulses));
    check("pulse width",  32'(max_run), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
